// File: rtl/btn_event_arbiter.sv
// Serialises button press pulses into a round-robin event stream. Press-to-o_valid latency is 2 cycles.
// Under backpressure (o_valid & !i_ready) the held event stays put, and further presses wait in the pending latches.
module btn_event_arbiter #(
    parameter  int NUM_BTN = 4,
    localparam int IDX_W   = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] i_btn_pulse,
    input  logic               i_ready,
    input  logic               i_clr_overflow,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_btn_idx,
    output logic [NUM_BTN-1:0] o_pending,
    output logic               o_overflow
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e              slot_q, slot_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] grant_vec;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W:0]     cand;
    logic               found;
    logic               ovf_q, ovf_d;
    logic               accept, slot_free, grant, merge;

    assign accept    = (slot_q == SLOT_FULL) & i_ready;
    assign slot_free = (slot_q == SLOT_EMPTY) | accept;
    assign grant     = slot_free & (|pend_q);

    // The search begins at rr_q and wraps by explicit compare, so non-power-of-2 NUM_BTN also works.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_BTN)) begin
                cand = cand - (IDX_W+1)'(NUM_BTN);
            end
            if (!found && pend_q[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant) begin
            grant_vec[winner] = 1'b1;
        end
    end

    // A press that arrives in the same cycle as its own grant re-arms the latch and is not a merge.
    assign merge  = |(i_btn_pulse & pend_q & ~grant_vec);
    assign pend_d = (pend_q & ~grant_vec) | i_btn_pulse;
    assign ovf_d  = merge | (ovf_q & ~i_clr_overflow);

    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        rr_d   = rr_q;
        case (slot_q)
            SLOT_EMPTY: begin
                if (grant) begin
                    slot_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (accept && !grant) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
        if (grant) begin
            idx_d = winner;
            if (winner == IDX_W'(NUM_BTN - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = winner + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= SLOT_EMPTY;
            pend_q <= '0;
            idx_q  <= '0;
            rr_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            pend_q <= pend_d;
            idx_q  <= idx_d;
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_valid    = (slot_q == SLOT_FULL);
    assign o_btn_idx  = idx_q;
    assign o_pending  = pend_q;
    assign o_overflow = ovf_q;

endmodule
